// File: rtl/conv_pkg.sv
// Shared FSM/handshake types and counter width helpers for the convolution scheduler.
package conv_pkg;

  typedef enum logic [3:0] {
    StFill,
    StCtrlGo,
    StCtrlHi,
    StCtrlLo,
    StCimWaitF,
    StCimGo,
    StCimHi,
    StCimLo,
    StFuncGo
  } state_e;

  typedef enum logic [1:0] {
    HsIdle,
    HsGo,
    HsHi,
    HsLo
  } hs_phase_e;

  function automatic int unsigned pos_w(input int unsigned img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int unsigned win_w(input int unsigned out_dim);
    return $clog2(out_dim * out_dim + 1);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Pixel stream, unit start/busy handshakes and status of the convolution scheduler.
interface conv_sched_if #(
  parameter int unsigned WinW = 10
);
  logic            i_pixel_valid;
  logic            o_pixel_ready;
  logic            o_ibuf_we;
  logic            o_ctrl_start;
  logic            i_ctrl_busy;
  logic            o_cim_start;
  logic            i_cim_busy;
  logic            o_func_start;
  logic            i_func_busy;
  logic            o_busy;
  logic            o_done;
  logic [WinW-1:0] o_win_count;

  modport slave (
    input  i_pixel_valid, i_ctrl_busy, i_cim_busy, i_func_busy,
    output o_pixel_ready, o_ibuf_we, o_ctrl_start, o_cim_start, o_func_start,
           o_busy, o_done, o_win_count
  );

  modport master (
    output i_pixel_valid, i_ctrl_busy, i_cim_busy, i_func_busy,
    input  o_pixel_ready, o_ibuf_we, o_ctrl_start, o_cim_start, o_func_start,
           o_busy, o_done, o_win_count
  );
endinterface

// File: rtl/sched_hs.sv
// One start/busy handshake step: a one-cycle start in GO, then wait for busy high, then low.
module sched_hs
  import conv_pkg::*;
(
  input  hs_phase_e phase_i,
  input  logic      busy_i,
  output logic      start_o,
  output logic      adv_o
);

  always_comb begin
    start_o = 1'b0;
    adv_o   = 1'b0;
    case (phase_i)
      HsGo: begin
        start_o = 1'b1;
        adv_o   = 1'b1;
      end
      HsHi:    adv_o = busy_i;
      HsLo:    adv_o = ~busy_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/conv_sched.sv
// Convolution layer scheduler: fills the line buffers, then sequences ctrl, crossbar and func.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned img_width  = 28,
  parameter int unsigned kernel_dim = 5
) (
  input logic         clk,
  input logic         rst,
  conv_sched_if.slave bus
);

  localparam int unsigned out_dim = img_width - kernel_dim + 1;
  localparam int unsigned PosW    = pos_w(img_width);
  localparam int unsigned WinW    = win_w(out_dim);
  localparam logic [PosW-1:0] PosLast = PosW'(img_width - 1);
  localparam logic [PosW-1:0] PosKern = PosW'(kernel_dim - 1);
  localparam logic [PosW-1:0] PosOne  = PosW'(1);
  localparam logic [WinW-1:0] WinOne  = WinW'(1);

  state_e          state_q, state_d;
  logic [PosW-1:0] row_q, row_d, col_q, col_d;
  logic [WinW-1:0] win_q, win_d;
  logic            last_q, last_d;
  hs_phase_e       ctrl_phase, cim_phase;
  logic            ctrl_start, ctrl_adv, cim_start, cim_adv;
  logic            accept, func_start, done;

  always_comb begin
    ctrl_phase = HsIdle;
    cim_phase  = HsIdle;
    case (state_q)
      StCtrlGo: ctrl_phase = HsGo;
      StCtrlHi: ctrl_phase = HsHi;
      StCtrlLo: ctrl_phase = HsLo;
      StCimGo:  cim_phase  = HsGo;
      StCimHi:  cim_phase  = HsHi;
      StCimLo:  cim_phase  = HsLo;
      default:  ;
    endcase
  end

  sched_hs u_ctrl_hs (
    .phase_i (ctrl_phase),
    .busy_i  (bus.i_ctrl_busy),
    .start_o (ctrl_start),
    .adv_o   (ctrl_adv)
  );

  sched_hs u_cim_hs (
    .phase_i (cim_phase),
    .busy_i  (bus.i_cim_busy),
    .start_o (cim_start),
    .adv_o   (cim_adv)
  );

  assign accept = bus.i_pixel_valid & (state_q == StFill);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    win_d      = win_q;
    last_d     = last_q;
    func_start = 1'b0;
    done       = 1'b0;
    case (state_q)
      StFill: begin
        if (accept) begin
          if (col_q == PosLast) begin
            col_d = '0;
            row_d = (row_q == PosLast) ? '0 : row_q + PosOne;
          end else begin
            col_d = col_q + PosOne;
          end
          // A full NxN window ends at this pixel once both coordinates reach N-1.
          if (row_q >= PosKern && col_q >= PosKern) begin
            state_d = StCtrlGo;
            last_d  = (row_q == PosLast) && (col_q == PosLast);
          end
        end
      end
      StCtrlGo:   if (ctrl_adv) state_d = StCtrlHi;
      StCtrlHi:   if (ctrl_adv) state_d = StCtrlLo;
      StCtrlLo:   if (ctrl_adv) state_d = StCimWaitF;
      StCimWaitF: if (!bus.i_func_busy) state_d = StCimGo;
      StCimGo:    if (cim_adv) state_d = StCimHi;
      StCimHi:    if (cim_adv) state_d = StCimLo;
      StCimLo:    if (cim_adv) state_d = StFuncGo;
      StFuncGo: begin
        func_start = 1'b1;
        win_d      = win_q + WinOne;
        state_d    = StFill;
        if (last_q) begin
          done   = 1'b1;
          win_d  = '0;
          row_d  = '0;
          col_d  = '0;
          last_d = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFill;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_pixel_ready = (state_q == StFill);
  assign bus.o_ibuf_we     = accept;
  assign bus.o_busy        = (state_q != StFill);
  assign bus.o_ctrl_start  = ctrl_start;
  assign bus.o_cim_start   = cim_start;
  assign bus.o_func_start  = func_start;
  assign bus.o_done        = done;
  // The retiring window is counted during FUNC_GO so the full frame count shows alongside o_done.
  assign bus.o_win_count   = win_q + WinW'(state_q == StFuncGo);

endmodule

// File: tb/tb_conv_sched.sv
// Directed scoreboard bench for conv_sched on a 6x6 image with a 3x3 kernel.
module tb_conv_sched;
  import conv_pkg::*;

  localparam int ImgW   = 6;
  localparam int KernD  = 3;
  localparam int NPix   = ImgW * ImgW;
  localparam int NWin   = (ImgW - KernD + 1) * (ImgW - KernD + 1);
  localparam int Budget = 3000;
  localparam int unsigned WinW = win_w(ImgW - KernD + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_sched_if #(.WinW(WinW)) bus ();

  conv_sched #(
    .img_width  (ImgW),
    .kernel_dim (KernD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int m_row, m_col, m_win;
  int sb_q[$];
  int trig_cyc;
  int n_acc, n_ctrl, n_cim, n_func, n_done;
  bit p_ctrl, p_cim, p_func;
  int ct_t, ci_t, fu_t;
  int func_hold;
  bit func_hold_arm, fall_pending, hold_seen;
  int exp_cim_cyc;
  bit cim_stuck, cim_stuck_arm, zero_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb_q.delete();
    m_row = 0; m_col = 0; m_win = 0;
    trig_cyc = -10;
    ct_t = 0; ci_t = 0; fu_t = 0;
    func_hold = 0; fall_pending = 0; exp_cim_cyc = -1;
    cim_stuck = 0; cim_stuck_arm = 0; zero_next = 0;
    p_ctrl = 0; p_cim = 0; p_func = 0;
    bus.i_ctrl_busy = 1'b0;
    bus.i_cim_busy  = 1'b0;
    bus.i_func_busy = 1'b0;
  endtask

  task automatic clear_counts();
    n_acc = 0; n_ctrl = 0; n_cim = 0; n_func = 0; n_done = 0;
  endtask

  // Runs at the negedge: checks this cycle's outputs, then drives the busy responders.
  task automatic monitor();
    int e;
    bit last;
    cyc++;
    if (!rst) begin
      chk("rst_ready", bus.o_pixel_ready, 1);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_win_count", bus.o_win_count, 0);
      chk("rst_strobes", {bus.o_ctrl_start, bus.o_cim_start, bus.o_func_start, bus.o_done}, 0);
      return;
    end
    if (bus.o_ibuf_we) chk("we_outside_fill", bus.o_busy, 0);
    if (bus.i_pixel_valid && !bus.o_busy) chk("we_on_accept", bus.o_ibuf_we, 1);
    chk("ctrl_consecutive", p_ctrl & bus.o_ctrl_start, 0);
    chk("cim_consecutive", p_cim & bus.o_cim_start, 0);
    chk("func_consecutive", p_func & bus.o_func_start, 0);
    chk("done_without_func", bus.o_done & ~bus.o_func_start, 0);
    if (zero_next) begin
      chk("count_cleared", bus.o_win_count, 0);
      zero_next = 0;
    end

    if (bus.o_ibuf_we) begin
      n_acc++;
      if (n_acc == 15) chk("no_ctrl_first_14", n_ctrl, 0);
      if (m_row >= KernD - 1 && m_col >= KernD - 1) begin
        last = (m_row == ImgW - 1) && (m_col == ImgW - 1);
        sb_q.push_back(m_win * 2 + int'(last));
        m_win = last ? 0 : m_win + 1;
        trig_cyc = cyc;
      end
      if (m_col == ImgW - 1) begin
        m_col = 0;
        m_row = (m_row == ImgW - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    if (bus.o_ctrl_start) begin
      n_ctrl++;
      chk("ctrl_latency", cyc, trig_cyc + 1);
    end
    if (bus.o_cim_start) begin
      n_cim++;
      chk("cim_while_func_busy", bus.i_func_busy, 0);
      if (exp_cim_cyc >= 0) begin
        chk("cim_after_func_fall", cyc, exp_cim_cyc);
        exp_cim_cyc = -1;
        hold_seen = 1;
      end
      if (cim_stuck_arm) begin
        cim_stuck = 1;
        cim_stuck_arm = 0;
      end
    end
    if (bus.o_func_start) begin
      n_func++;
      chk("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("win_count", bus.o_win_count, e / 2 + 1);
        chk("done_flag", bus.o_done, e % 2);
      end
      if (func_hold_arm) begin
        func_hold = 20;
        func_hold_arm = 0;
      end
    end
    if (bus.o_done) begin
      n_done++;
      zero_next = 1;
    end
    p_ctrl = bus.o_ctrl_start;
    p_cim  = bus.o_cim_start;
    p_func = bus.o_func_start;

    if (bus.o_ctrl_start) ct_t = 3; else if (ct_t > 0) ct_t--;
    if (bus.o_cim_start) ci_t = 3; else if (ci_t > 0) ci_t--;
    if (bus.o_func_start) fu_t = 3; else if (fu_t > 0) fu_t--;
    bus.i_ctrl_busy = (ct_t == 1 || ct_t == 2);
    bus.i_cim_busy  = cim_stuck || (ci_t == 1 || ci_t == 2);
    if (func_hold > 0) begin
      bus.i_func_busy = 1'b1;
      func_hold--;
      if (func_hold == 0) fall_pending = 1;
    end else begin
      bus.i_func_busy = (fu_t == 1 || fu_t == 2);
      if (fall_pending && !bus.i_func_busy) begin
        exp_cim_cyc = cyc + 1;
        fall_pending = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    int g;
    clear_counts();
    g = 0;
    bus.i_pixel_valid = 1'b1;
    while (n_acc < NPix && g < Budget) begin
      cycle();
      g++;
    end
    bus.i_pixel_valid = 1'b0;
    while (n_done == 0 && g < Budget) begin
      cycle();
      g++;
    end
    repeat (4) cycle();
    chk({tag, "_accepts"}, n_acc, NPix);
    chk({tag, "_ctrl_pulses"}, n_ctrl, NWin);
    chk({tag, "_cim_pulses"}, n_cim, NWin);
    chk({tag, "_func_pulses"}, n_func, NWin);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_sb_drained"}, sb_q.size(), 0);
    chk({tag, "_idle_count"}, bus.o_win_count, 0);
  endtask

  initial begin
    int g;
    rst = 1'b0;
    bus.i_pixel_valid = 1'b0;
    hold_seen = 0;
    clear_model();
    clear_counts();
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", bus.o_pixel_ready, 1);
    chk("post_rst_busy", bus.o_busy, 0);

    run_frame("frame1");

    func_hold_arm = 1;
    run_frame("frame2");
    chk("func_hold_path", hold_seen, 1);

    // Park in CIM_LO with crossbar busy stuck high, then reset mid-window.
    clear_counts();
    g = 0;
    bus.i_pixel_valid = 1'b1;
    while (n_func < 3 && g < Budget) begin
      cycle();
      g++;
    end
    cim_stuck_arm = 1;
    while (!cim_stuck && g < Budget) begin
      cycle();
      g++;
    end
    chk("stuck_reached", cim_stuck, 1);
    repeat (40) cycle();
    chk("stuck_busy", bus.o_busy, 1);
    chk("stuck_ctrl", n_ctrl, 4);
    chk("stuck_cim", n_cim, 4);
    chk("stuck_func", n_func, 3);
    chk("stuck_count", bus.o_win_count, 3);
    bus.i_pixel_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", bus.o_busy, 0);
    chk("async_rst_ready", bus.o_pixel_ready, 1);
    chk("async_rst_count", bus.o_win_count, 0);
    clear_model();
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    chk("release_count", bus.o_win_count, 0);

    run_frame("frame4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
